// File: rtl/disp_pkg.sv
// Shared types and constants for the 3-digit scanned display driver.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  localparam int NUM_DIGITS = 3;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_LUT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100,
    7'b0110000, 7'b0011001, 7'b0010010,
    7'b0000010, 7'b1111000, 7'b0000000,
    7'b0010000
  };

  function automatic logic [6:0] seg_of(
    input logic [3:0] d
  );
    logic [6:0] s;
    s = SEG_BLANK;
    if (d < 4'd10) s = SEG_LUT[d];
    return s;
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Load handshake between the multiplier datapath and the display driver.
// The producer drives load/value; the driver reports busy.
interface seg_scan_driver_if;
  logic       load;
  logic [7:0] value;
  logic       busy;

  modport master (
    output load,
    output value,
    input  busy
  );

  modport slave (
    input  load,
    input  value,
    output busy
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 8-bit binary to 3-digit BCD.
// One shift per cycle; done_pulse marks the COMMIT cycle.
module bin2bcd_seq
  import disp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [7:0]  value,
  output logic        busy,
  output logic        done_pulse,
  output logic [11:0] bcd
);

  state_e      r_state;
  logic [7:0]  r_bin;
  logic [11:0] r_bcd;
  logic [2:0]  r_cnt;
  logic [11:0] w_adj;

  // Correction is applied to the pre-shift nibbles
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5)
        w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (load) begin
            r_bin   <= value;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          {r_bcd, r_bin} <= {w_adj[10:0], r_bin, 1'b0};
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) r_state <= ST_COMMIT;
        end
        ST_COMMIT: r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy       = (r_state != ST_IDLE);
  assign done_pulse = (r_state == ST_COMMIT);
  assign bcd        = r_bcd;

endmodule

// File: rtl/seg_scan_driver.sv
// Top level: refresh scan, display registers, blanking and
// registered anode/segment outputs fed by the BCD converter.
module seg_scan_driver
  import disp_pkg::*;
#(
  parameter int REFRESH_TICKS = 80000
) (
  input  logic               clk,
  input  logic               rst,
  seg_scan_driver_if.slave   bus,
  output logic [2:0]         an,
  output logic [6:0]         seg
);

  localparam int TW = $clog2(REFRESH_TICKS);
  localparam logic [TW-1:0] TICK_MAX = TW'(REFRESH_TICKS - 1);

  logic          w_busy;
  logic          w_done;
  logic [11:0]   w_bcd;

  logic [TW-1:0] r_tick;
  logic [1:0]    r_idx;
  logic [3:0]    r_dig_h;
  logic [3:0]    r_dig_t;
  logic [3:0]    r_dig_o;
  logic [2:0]    r_an;
  logic [6:0]    r_seg;

  logic          w_wrap;
  logic [1:0]    w_idx_nxt;
  logic [3:0]    w_h_nxt;
  logic [3:0]    w_t_nxt;
  logic [3:0]    w_o_nxt;
  logic [2:0]    w_an_nxt;
  logic [6:0]    w_seg_nxt;

  bin2bcd_seq u_conv (
    .clk        (clk),
    .rst        (rst),
    .load       (bus.load),
    .value      (bus.value),
    .busy       (w_busy),
    .done_pulse (w_done),
    .bcd        (w_bcd)
  );

  assign bus.busy = w_busy;

  assign w_wrap = (r_tick == TICK_MAX);

  // Outputs are built from next-state values so index and digit
  // always switch together, even when COMMIT meets a wrap.
  always_comb begin
    w_idx_nxt = r_idx;
    if (w_wrap)
      w_idx_nxt = (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
    w_h_nxt = w_done ? w_bcd[11:8] : r_dig_h;
    w_t_nxt = w_done ? w_bcd[7:4]  : r_dig_t;
    w_o_nxt = w_done ? w_bcd[3:0]  : r_dig_o;
  end

  always_comb begin
    w_an_nxt  = 3'b110;
    w_seg_nxt = seg_of(w_o_nxt);
    unique case (1'b1)
      (w_idx_nxt == 2'd1): begin
        w_an_nxt  = 3'b101;
        w_seg_nxt = (w_h_nxt == 4'd0 && w_t_nxt == 4'd0)
                  ? SEG_BLANK : seg_of(w_t_nxt);
      end
      (w_idx_nxt == 2'd2): begin
        w_an_nxt  = 3'b011;
        w_seg_nxt = (w_h_nxt == 4'd0)
                  ? SEG_BLANK : seg_of(w_h_nxt);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick  <= '0;
      r_idx   <= 2'd0;
      r_dig_h <= 4'd0;
      r_dig_t <= 4'd0;
      r_dig_o <= 4'd0;
      r_an    <= 3'b110;
      r_seg   <= 7'b1000000;
    end else begin
      r_tick  <= w_wrap ? '0 : r_tick + 1'b1;
      r_idx   <= w_idx_nxt;
      r_dig_h <= w_h_nxt;
      r_dig_t <= w_t_nxt;
      r_dig_o <= w_o_nxt;
      r_an    <= w_an_nxt;
      r_seg   <= w_seg_nxt;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench: decimal reference model predicts every cycle,
// an independent monitor compares busy/an/seg against it.
module tb_seg_scan_driver;

  localparam int RT = 4;

  typedef struct packed {
    logic       busy;
    logic [2:0] an;
    logic [6:0] seg;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] an;
  logic [6:0] seg;

  seg_scan_driver_if u_if ();

  seg_scan_driver #(.REFRESH_TICKS(RT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if),
    .an  (an),
    .seg (seg)
  );

  always #5 clk = ~clk;

  logic [6:0] tbl [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int m_tick = 0;
  int m_idx  = 0;
  int m_disp = 0;
  int m_left = 0;
  int m_pend = 0;

  function automatic exp_t predict(int idx, int d, bit b);
    exp_t e;
    e.busy = b;
    if (idx == 0) begin
      e.an  = 3'b110;
      e.seg = tbl[d % 10];
    end else if (idx == 1) begin
      e.an  = 3'b101;
      e.seg = (d < 10) ? 7'h7F : tbl[(d / 10) % 10];
    end else begin
      e.an  = 3'b011;
      e.seg = (d < 100) ? 7'h7F : tbl[d / 100];
    end
    return e;
  endfunction

  // Reference model: advances on each edge from the pre-edge inputs
  always @(posedge clk) begin
    if (rst) begin
      m_tick = 0;
      m_idx  = 0;
      m_disp = 0;
      m_left = 0;
    end else begin
      if (m_tick == RT - 1) begin
        m_tick = 0;
        m_idx  = (m_idx + 1) % 3;
      end else begin
        m_tick = m_tick + 1;
      end
      if (m_left == 0) begin
        if (u_if.load) begin
          m_left = 9;
          m_pend = int'(u_if.value);
        end
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) m_disp = m_pend;
      end
    end
    q.push_back(predict(m_idx, m_disp, m_left != 0));
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_tests++;
      if (u_if.busy !== e.busy || an !== e.an || seg !== e.seg) begin
        n_fail++;
        $display("FAIL cycle%0d busy/an/seg got %b/%b/%b want %b/%b/%b",
                 cyc, u_if.busy, an, seg, e.busy, e.an, e.seg);
      end
    end
  end

  task automatic do_load(input logic [7:0] v);
    @(negedge clk);
    u_if.load  = 1'b1;
    u_if.value = v;
    @(negedge clk);
    u_if.load  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Issue a load so that its COMMIT edge coincides with a tick wrap
  task automatic load_on_wrap(input logic [7:0] v);
    int guard;
    guard = 0;
    @(negedge clk);
    while (m_tick != 2 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    u_if.load  = 1'b1;
    u_if.value = v;
    @(negedge clk);
    u_if.load  = 1'b0;
    idle(20);
  endtask

  initial begin
    u_if.load  = 1'b0;
    u_if.value = 8'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(14);

    do_load(8'd255);
    idle(16);
    do_load(8'd7);
    idle(16);
    do_load(8'd105);
    idle(16);

    do_load(8'd42);
    idle(1);
    do_load(8'd99);
    idle(20);

    do_load(8'd200);
    idle(3);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(10);
    do_load(8'd200);
    idle(16);

    load_on_wrap(8'd123);
    load_on_wrap(8'd9);
    load_on_wrap(8'd250);
    for (int i = 0; i < 4; i++)
      load_on_wrap(8'($urandom_range(0, 255)));

    for (int i = 0; i < 40; i++) begin
      do_load(8'($urandom_range(0, 255)));
      idle($urandom_range(0, 14));
    end
    idle(20);

    if (n_tests < 12) begin
      n_fail++;
      $display("FAIL count got %0d comparisons want >=12", n_tests);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
